snake_body_buffer: RTL and testbench
====================================

Name: snake_body_buffer

Overview:
- Circular body store for the snake: write end pushes each new head position, read end pops the vacated tail position for the pixel generator to erase.
- Maintains a 128-cell occupancy bitmap for self-collision detection.
- Sits between the move unit (head producer) and pixel generation (tail consumer). Replaces the generic FIFO plus pulse-generator pairing.

Parameters:
- DEPTH, 128, maximum body length in segments (8 rows x 16 cols); power of two.
- INIT_LEN, 3, segments laid down by initialisation (1..16).
- INIT_ROW, 3, row y used for the initial body.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled; 1 in any state begins initialisation.
- step  in  1  one-cycle strobe; headPos and grow are valid.
- headPos  in  8  {x[3:0], y[3:0]}; legal when y<8.
- grow  in  1  with step: keep the tail (food eaten).
- tailPos  out  8  position released by the last pop.
- tailValid  out  1  one-cycle pulse: tailPos must be erased.
- headOut  out  8  most recently written segment.
- length  out  8  current segment count.
- full  out  1  length==DEPTH.
- collision  out  1  sticky; head hit body or left field.
- busy  out  1  high during INIT.

Behaviour:
- Reset, clock and sequencing: one clock; reset is asynchronous and active-low. While reset=0, all outputs are 0, pointers are 0, the bitmap is cleared and the state is IDLE.
- Storage: DEPTH x 8 ring. wrPtr is the next free slot and rdPtr is the tail; both wrap mod DEPTH. The bitmap index is y*16+x.
- IDLE: step ignored. start=1 goes to INIT.
- INIT:
  - Clear the bitmap, pointers, length and collision on entry cycle 0.
  - Over the next INIT_LEN cycles, write {k, INIT_ROW} for k = 0..INIT_LEN-1, one per cycle, setting bitmap bits.
  - busy=1 throughout. step is ignored. Then go to RUN with length=INIT_LEN and headOut={INIT_LEN-1, INIT_ROW}.
- RUN, step at edge N; all results are registered and visible after edge N+1:
  - Out of field: headPos y>=8 sets collision=1, goes to DEAD, no write.
  - Effective grow: growEff = grow & ~full.
  - Vacating tail: tailCell = mem[rdPtr] when ~growEff.
  - Self-hit: hit = bitmap[headPos] & ~(~growEff & headPos==tailCell). Moving into the cell being vacated this step is legal.
  - hit=1: collision=1, go to DEAD. No write, no pop, length unchanged.
  - Otherwise write headPos at wrPtr, set its bit, wrPtr++ and update headOut.
  - If growEff: length+1, tailValid stays 0.
  - Else: pop — tailPos=tailCell, tailValid=1 for exactly one cycle, rdPtr++. Clear the tailCell bit unless headPos==tailCell, in which case the bit stays set.
- full: grow is treated as 0. Length saturates at DEPTH and the snake just moves.
- DEAD: outputs frozen, collision held at 1. step is ignored. start goes to INIT.
- start during RUN or INIT: restart INIT immediately; no tailValid is emitted for discarded segments.
- start and step in the same cycle: start wins and step is dropped.
- Reset mid-operation: immediate clear, same as power-up.
- Invariant (checked by assertion): popcount(bitmap)==length in RUN.

Decomposition:
- Shared package holds:
  - POS_W=8
  - GRID_W=16, GRID_H=8
  - position field slicing (x=[7:4], y=[3:0])
  - state encoding IDLE/INIT/RUN/DEAD
- One natural sub-module: snake_ring_mem, a DEPTH x POS_W register array with wrap-around pointers and asynchronous read at rdPtr.

Test Plan:
- Reset then start pulse -> busy=1 for 1+3 cycles; then length=3, headOut=0x23, tailValid never pulsed, bitmap bits {0x03, 0x13, 0x23} set.
- step headPos=0x33, grow=0 -> next cycle tailValid=1 for one cycle with tailPos=0x03, length=3, headOut=0x33.
- step headPos=0x43, grow=1 -> tailValid=0, length=4; a following grow=0 step pops 0x13.
- Length-4 snake loops and steps head into its own middle segment -> collision=1, state DEAD; later steps produce no tailValid; start clears collision and reinitialises.
- 2x2 loop with length 4: head steps onto the vacating tail cell -> no collision, tailValid=1 with tailPos equal to headPos, bit stays set.
- Out of field and saturation:
  - headPos=0x28 (y=8) -> collision=1.
  - Separate run: grow to 128 segments -> full=1; a further grow step pops the tail and length stays 128.
  - reset=0 mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/snake_body_buffer_pkg.sv
// Shared definitions for the snake body buffer.
// Holds the position encoding ({x[3:0], y[3:0]}), the playfield size, the
// controller state encoding and helpers that slice a position or turn it
// into an occupancy-bitmap index (y*16+x).
package snake_body_buffer_pkg;

  localparam int POS_W  = 8;
  localparam int GRID_W = 16;
  localparam int GRID_H = 8;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int CELL_W = $clog2(CELLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DEAD = 2'd3
  } state_t;

  function automatic logic [3:0] pos_x(input logic [POS_W-1:0] p);
    return p[7:4];
  endfunction

  function automatic logic [3:0] pos_y(input logic [POS_W-1:0] p);
    return p[3:0];
  endfunction

  // Only meaningful for in-field positions (y < 8), so y[3] is dropped.
  function automatic logic [CELL_W-1:0] cell_idx(input logic [POS_W-1:0] p);
    return {p[2:0], p[7:4]};
  endfunction

endpackage

// File: rtl/snake_ring_mem.sv
// Ring store for body segments.
// Ports:
//   clk, reset   - system clock, asynchronous active-low reset (pointers only)
//   clear        - synchronous pointer clear
//   wr_en/wr_data- push a segment at the write pointer
//   rd_en        - advance the read (tail) pointer
//   rd_data      - asynchronous read of the segment at the tail pointer
module snake_ring_mem
  import snake_body_buffer_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [POS_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [POS_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [POS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the wrap-around.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/snake_body_buffer.sv
// Snake body buffer: circular store of body segments plus a 128-cell
// occupancy bitmap used for self-collision detection.
// Ports:
//   clk, reset  - system clock, asynchronous active-low reset
//   start       - (re)start initialisation from any state
//   step, headPos, grow - move request from the move unit
//   tailPos, tailValid  - vacated cell to erase (one-cycle pulse)
//   headOut     - most recently written segment
//   length, full- current segment count, length==DEPTH
//   collision   - sticky: head hit the body or left the field
//   busy        - high while the initial body is laid down
module snake_body_buffer
  import snake_body_buffer_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int INIT_LEN = 3,
  parameter int INIT_ROW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [POS_W-1:0] headPos,
  input  logic             grow,
  output logic [POS_W-1:0] tailPos,
  output logic             tailValid,
  output logic [POS_W-1:0] headOut,
  output logic [7:0]       length,
  output logic             full,
  output logic             collision,
  output logic             busy
);

  state_t            state;
  logic [4:0]        init_cnt;
  logic [CELLS-1:0]  bitmap;

  logic              grow_eff;
  logic [POS_W-1:0]  tail_cell;
  logic              same_cell;
  logic              off_field;
  logic              self_hit;
  logic              move_ok;
  logic              init_wr;
  logic [3:0]        init_k;
  logic [POS_W-1:0]  init_pos;
  logic              ring_clear;
  logic              ring_wr;
  logic              ring_rd;
  logic [POS_W-1:0]  ring_wdata;

  assign full = (length == 8'(DEPTH));

  snake_ring_mem #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .reset   (reset),
    .clear   (ring_clear),
    .wr_en   (ring_wr),
    .wr_data (ring_wdata),
    .rd_en   (ring_rd),
    .rd_data (tail_cell)
  );

  always_comb begin
    grow_eff  = grow & ~full;
    same_cell = (headPos == tail_cell);
    off_field = (pos_y(headPos) >= 4'(GRID_H));
    // Stepping onto the cell that this same step vacates is legal.
    self_hit  = bitmap[cell_idx(headPos)] & ~(~grow_eff & same_cell);
    move_ok   = (state == RUN) & step & ~start & ~off_field & ~self_hit;
    // init_cnt 0 is the clearing cycle; counts 1..INIT_LEN write segment k=cnt-1.
    init_wr   = (state == INIT) & ~start & (init_cnt != 5'd0);
    init_k    = 4'(init_cnt - 5'd1);
    init_pos  = {init_k, 4'(INIT_ROW)};
    ring_clear = (state == INIT) & ~start & (init_cnt == 5'd0);
    ring_wr    = init_wr | move_ok;
    ring_wdata = init_wr ? init_pos : headPos;
    ring_rd    = move_ok & ~grow_eff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      init_cnt  <= '0;
      bitmap    <= '0;
      tailPos   <= '0;
      tailValid <= 1'b0;
      headOut   <= '0;
      length    <= '0;
      collision <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tailValid <= 1'b0;
      if (start) begin
        // start wins over a simultaneous step; discarded segments are not popped.
        state    <= INIT;
        init_cnt <= '0;
        busy     <= 1'b1;
      end else begin
        case (state)
          INIT: begin
            if (init_cnt == 5'd0) begin
              bitmap    <= '0;
              length    <= '0;
              collision <= 1'b0;
              headOut   <= '0;
              tailPos   <= '0;
              init_cnt  <= 5'd1;
            end else begin
              bitmap[cell_idx(init_pos)] <= 1'b1;
              headOut <= init_pos;
              length  <= length + 8'd1;
              if (init_cnt == 5'(INIT_LEN)) begin
                state <= RUN;
                busy  <= 1'b0;
              end else begin
                init_cnt <= init_cnt + 5'd1;
              end
            end
          end
          RUN: begin
            if (step) begin
              if (off_field || self_hit) begin
                collision <= 1'b1;
                state     <= DEAD;
              end else begin
                headOut <= headPos;
                if (grow_eff) begin
                  length <= length + 8'd1;
                end else begin
                  tailPos   <= tail_cell;
                  tailValid <= 1'b1;
                  bitmap[cell_idx(tail_cell)] <= 1'b0;
                end
                // Placed after the tail clear so a head landing on the
                // vacated cell keeps its bit set.
                bitmap[cell_idx(headPos)] <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The occupancy bitmap must track the body exactly while moving.
  ap_popcount: assert property (@(posedge clk) disable iff (!reset)
    (state == RUN) |-> ($countones(bitmap) == int'(length)));

endmodule

// File: tb/tb_snake_body_buffer.sv
module tb_snake_body_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic [7:0] headPos = 8'h00;
  logic       grow = 1'b0;
  logic [7:0] tailPos;
  logic       tailValid;
  logic [7:0] headOut;
  logic [7:0] length;
  logic       full;
  logic       collision;
  logic       busy;

  int errs = 0;
  int checks = 0;
  logic [7:0] path [$];

  snake_body_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .headPos   (headPos),
    .grow      (grow),
    .tailPos   (tailPos),
    .tailValid (tailValid),
    .headOut   (headOut),
    .length    (length),
    .full      (full),
    .collision (collision),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic [7:0] p, input logic g);
    headPos = p;
    grow    = g;
    step    = 1'b1;
    cyc();
    step = 1'b0;
    grow = 1'b0;
  endtask

  task automatic run_init();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
  endtask

  function automatic logic [7:0] pos(input int x, input int y);
    return {4'(x), 4'(y)};
  endfunction

  initial begin
    // Asynchronous reset
    #3 reset = 1'b0;
    #1;
    check_eq("rst_length", length, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_coll", collision, 0);
    check_eq("rst_head", headOut, 0);
    check_eq("rst_tv", tailValid, 0);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();

    // Initialisation: busy for 1+3 cycles
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("init_busy0", busy, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("init_busy", busy, 1);
      check_eq("init_tv", tailValid, 0);
    end
    cyc();
    check_eq("init_done_busy", busy, 0);
    check_eq("init_len", length, 3);
    check_eq("init_head", headOut, 8'h23);
    check_eq("init_bm03", dut.bitmap[48], 1);
    check_eq("init_bm13", dut.bitmap[49], 1);
    check_eq("init_bm23", dut.bitmap[50], 1);
    check_eq("init_popcnt", $countones(dut.bitmap), 3);

    // Plain move pops the tail
    do_step(8'h33, 1'b0);
    check_eq("mv_tv", tailValid, 1);
    check_eq("mv_tail", tailPos, 8'h03);
    check_eq("mv_len", length, 3);
    check_eq("mv_head", headOut, 8'h33);
    cyc();
    check_eq("mv_tv_pulse", tailValid, 0);

    // Grow keeps the tail, the next move pops it
    do_step(8'h43, 1'b1);
    check_eq("gr_tv", tailValid, 0);
    check_eq("gr_len", length, 4);
    do_step(8'h53, 1'b0);
    check_eq("gr2_tv", tailValid, 1);
    check_eq("gr2_tail", tailPos, 8'h13);
    check_eq("gr2_len", length, 4);

    // Loop back into the neck: body 43,53,54,44 then head to 54
    do_step(8'h54, 1'b0);
    check_eq("lp1_tail", tailPos, 8'h23);
    do_step(8'h44, 1'b0);
    check_eq("lp2_tail", tailPos, 8'h33);
    do_step(8'h54, 1'b0);
    check_eq("hit_coll", collision, 1);
    check_eq("hit_tv", tailValid, 0);
    check_eq("hit_len", length, 4);
    check_eq("hit_head", headOut, 8'h44);
    do_step(8'h64, 1'b0);
    check_eq("dead_tv", tailValid, 0);
    check_eq("dead_coll", collision, 1);
    check_eq("dead_head", headOut, 8'h44);

    // Restart clears collision
    run_init();
    check_eq("re_coll", collision, 0);
    check_eq("re_len", length, 3);
    check_eq("re_head", headOut, 8'h23);

    // 2x2 loop: head onto the vacating tail cell
    do_step(8'h24, 1'b1);
    check_eq("sq_len", length, 4);
    do_step(8'h14, 1'b0);
    check_eq("sq_tail1", tailPos, 8'h03);
    do_step(8'h13, 1'b0);
    check_eq("sq_coll", collision, 0);
    check_eq("sq_tv", tailValid, 1);
    check_eq("sq_tail2", tailPos, 8'h13);
    check_eq("sq_len2", length, 4);
    check_eq("sq_bm13", dut.bitmap[49], 1);
    check_eq("sq_head", headOut, 8'h13);

    // Leaving the field
    do_step(8'h28, 1'b0);
    check_eq("oof_coll", collision, 1);
    check_eq("oof_tv", tailValid, 0);
    check_eq("oof_len", length, 4);

    // Saturation: visit every remaining cell with grow=1
    run_init();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 3; i++)
        path.push_back(pos((r % 2 == 0) ? 2 - i : i, 4 + r));
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 13; i++)
        path.push_back(pos((r % 2 == 0) ? 3 + i : 15 - i, 7 - r));
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 16; i++)
        path.push_back(pos((r % 2 == 0) ? 15 - i : i, 2 - r));
    for (int i = 0; i < path.size(); i++) begin
      do_step(path[i], 1'b1);
      if (i == path.size() - 2) begin
        check_eq("sat_len127", length, 127);
        check_eq("sat_full127", full, 0);
      end
    end
    check_eq("sat_len", length, 128);
    check_eq("sat_full", full, 1);
    check_eq("sat_coll", collision, 0);
    check_eq("sat_popcnt", $countones(dut.bitmap), 128);
    // Full: grow ignored, head moves onto the vacating tail
    do_step(8'h03, 1'b1);
    check_eq("satmv_tv", tailValid, 1);
    check_eq("satmv_tail", tailPos, 8'h03);
    check_eq("satmv_len", length, 128);
    check_eq("satmv_full", full, 1);
    check_eq("satmv_coll", collision, 0);
    check_eq("satmv_head", headOut, 8'h03);

    // Reset mid-run, away from a clock edge
    #2 reset = 1'b0;
    #1;
    check_eq("mr_len", length, 0);
    check_eq("mr_full", full, 0);
    check_eq("mr_head", headOut, 0);
    check_eq("mr_tail", tailPos, 0);
    check_eq("mr_tv", tailValid, 0);
    check_eq("mr_coll", collision, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_bitmap", $countones(dut.bitmap), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
